// File: rtl/ahead_sub16_pipe.sv
// Two-stage pipelined 16-bit lookahead subtractor: D = A - B - BIN.
// Stage 1 resolves the low byte and its borrow; stage 2 resolves the high byte and flags.
module ahead_sub16_pipe (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        BIN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] D,
  output logic        bout,
  output logic        ovf
);

  // 4-bit generate/propagate lookahead group; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic       s1_valid;
  logic [7:0] s1_d_lo;
  logic       s1_borrow;
  logic [7:0] s1_a_hi;
  logic [7:0] s1_b_hi;

  logic       s2_free;
  logic       s1_adv;
  logic       accept;

  logic [4:0] lo0;
  logic [4:0] lo1;
  logic [4:0] hi0;
  logic [4:0] hi1;
  logic [7:0] d_hi;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  // Subtraction as A + ~B + ~BIN; a borrow is the complement of the carry.
  always_comb begin
    lo0 = cla4(A[3:0], ~B[3:0], ~BIN);
    lo1 = cla4(A[7:4], ~B[7:4], lo0[4]);
    hi0 = cla4(s1_a_hi[3:0], ~s1_b_hi[3:0], ~s1_borrow);
    hi1 = cla4(s1_a_hi[7:4], ~s1_b_hi[7:4], hi0[4]);
    d_hi = {hi1[3:0], hi0[3:0]};
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_d_lo   <= 8'h00;
      s1_borrow <= 1'b0;
      s1_a_hi   <= 8'h00;
      s1_b_hi   <= 8'h00;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_d_lo   <= {lo1[3:0], lo0[3:0]};
      s1_borrow <= ~lo1[4];
      s1_a_hi   <= A[15:8];
      s1_b_hi   <= B[15:8];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register only loads on advance, so D is held through stalls and idle cycles.
  always_ff @(posedge clk1) begin
    if (rst) begin
      out_valid <= 1'b0;
      D         <= 16'h0000;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      D         <= {d_hi, s1_d_lo};
      bout      <= ~hi1[4];
      ovf       <= (s1_a_hi[7] ^ s1_b_hi[7]) & (d_hi[7] ^ s1_a_hi[7]);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahead_sub16_pipe.sv
// Self-checking bench for ahead_sub16_pipe: vector table, handshake corner cases and a
// random sweep, all checked through an in-order scoreboard.
module tb_ahead_sub16_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    exp_t        e;
  } vec_t;

  logic        clk1;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        BIN;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        bout;
  logic        ovf;

  exp_t q[$];
  int   n_chk;
  int   n_err;
  int   n_acc;
  logic rnd_en;

  ahead_sub16_pipe dut (
    .clk1     (clk1),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .BIN      (BIN),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .bout     (bout),
    .ovf      (ovf)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] r;
    exp_t        e;
    r      = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
    e.d    = r[15:0];
    e.bout = r[16];
    e.ovf  = (a[15] != b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one operand set; push its expected result on the cycle it is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input exp_t e);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    BIN      = bin;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk1);
      if (in_ready) begin
        q.push_back(e);
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk1);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk1);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  // Accept at edge N: out_valid still 0 after edge N, 1 after edge N+1.
  task automatic lat_test(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input exp_t e, input string name);
    send(a, b, bin, e);
    chk({name, "_lat_n"}, out_valid, 0);
    @(posedge clk1);
    #1;
    chk({name, "_lat_n1"}, out_valid, 1);
    drain();
  endtask

  // Scoreboard monitor: every handshaked output must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: got D=%h bout=%b ovf=%b, expected none",
                   D, bout, ovf);
        end else begin
          e = q.pop_front();
          chk("result", {14'h0, D, bout, ovf}, {14'h0, e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk1);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t        tv[12];
  logic [15:0] held;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rbin;
  int          acc0;
  int          t;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    n_acc     = 0;
    rnd_en    = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 16'h0;
    B         = 16'h0;
    BIN       = 1'b0;

    tv[0]  = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    tv[1]  = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1}};
    tv[2]  = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1}};
    tv[3]  = '{16'h0100, 16'h0000, 1'b1, '{16'h00FF, 1'b0, 1'b0}};
    tv[4]  = '{16'h0000, 16'hFFFF, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    tv[5]  = '{16'h1234, 16'h1234, 1'b0, '{16'h0000, 1'b0, 1'b0}};
    tv[6]  = '{16'h1234, 16'h1234, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
    tv[7]  = '{16'hFFFF, 16'h0000, 1'b0, '{16'hFFFF, 1'b0, 1'b0}};
    tv[8]  = '{16'h8000, 16'h7FFF, 1'b0, '{16'h0001, 1'b0, 1'b1}};
    tv[9]  = '{16'h00FF, 16'h0001, 1'b1, '{16'h00FD, 1'b0, 1'b0}};
    tv[10] = '{16'h0080, 16'h0081, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    tv[11] = '{16'hABCD, 16'h1234, 1'b0, '{16'h9999, 1'b0, 1'b0}};

    // Reset state
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {D, bout, ovf}, 0);
    @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk1);
    #1;

    lat_test(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0}, "basic");

    // Vector table, back-to-back with out_ready high
    for (int i = 0; i < 12; i++) send(tv[i].a, tv[i].b, tv[i].bin, tv[i].e);
    drain();

    // Backpressure: pipeline fills after two accepts, D held, then drains one per cycle
    out_ready = 1'b0;
    acc0      = n_acc;
    fork
      begin
        send(16'h1111, 16'h0001, 1'b0, model(16'h1111, 16'h0001, 1'b0));
        send(16'h2222, 16'h0002, 1'b1, model(16'h2222, 16'h0002, 1'b1));
        send(16'h0000, 16'h3333, 1'b0, model(16'h0000, 16'h3333, 1'b0));
        send(16'h8001, 16'h0004, 1'b1, model(16'h8001, 16'h0004, 1'b1));
      end
      begin
        t = 0;
        @(negedge clk1);
        while (in_ready && t < 20) begin
          @(negedge clk1);
          t++;
        end
        chk("accepts_before_full", n_acc - acc0, 2);
        held = D;
        repeat (4) begin
          @(negedge clk1);
          chk("stall_hold", {out_valid, in_ready, D}, {1'b1, 1'b0, held});
        end
        @(posedge clk1);
        #1 out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk1);
          chk("drain_valid", out_valid, 1);
        end
      end
    join
    drain();

    // Reset mid-flight: both in-flight results discarded
    @(posedge clk1);
    #1 out_ready = 1'b0;
    send(16'h1234, 16'h0001, 1'b0, model(16'h1234, 16'h0001, 1'b0));
    send(16'h5678, 16'h0008, 1'b0, model(16'h5678, 16'h0008, 1'b0));
    rst = 1'b1;
    q.delete();
    @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {D, bout, ovf}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk1);
    #1 out_ready = 1'b1;
    repeat (4) @(posedge clk1);
    #1;
    lat_test(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1}, "after_rst");

    // Random sweep with random out_ready
    rnd_en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    rnd_en = 1'b0;
    @(posedge clk1);
    #2 out_ready = 1'b1;
    drain();

    if (n_err == 0) $display("success!");
    else $display("failed");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
